// File: rtl/poc_ctrl.sv
// poc_ctrl: CPU-side SR/BR register pair feeding an 8-bit printer over a TR/RDY handshake.
module poc_ctrl #(
  parameter int unsigned DW          = 8,
  parameter int unsigned REQ_TIMEOUT = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cs,
  input  logic          i_rw,
  input  logic          i_addr,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout,
  output logic          o_irq,
  input  logic          i_rdy,
  output logic          o_tr,
  output logic [DW-1:0] o_pd
);

  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] br_q, br_d;
  logic [DW-1:0] pd_q, pd_d;
  logic          tr_q, tr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_q, rdy_d;
  logic          ien_q, ien_d;
  logic          ovr_q, ovr_d;
  logic          toerr_q, toerr_d;

  logic          wr_sr;
  logic          wr_br;
  logic [7:0]    sr;

  assign wr_sr = i_cs & i_rw & ~i_addr;
  assign wr_br = i_cs & i_rw &  i_addr;
  assign sr    = {rdy_q, 4'b0000, toerr_q, ovr_q, ien_q};

  // State and register file update; synchronous reset to the idle/empty state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      br_q    <= '0;
      pd_q    <= '0;
      tr_q    <= 1'b0;
      cnt_q   <= '0;
      rdy_q   <= 1'b1;
      ien_q   <= 1'b0;
      ovr_q   <= 1'b0;
      toerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      br_q    <= br_d;
      pd_q    <= pd_d;
      tr_q    <= tr_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      ien_q   <= ien_d;
      ovr_q   <= ovr_d;
      toerr_q <= toerr_d;
    end
  end

  // Next-state: CPU register writes, then the printer handshake FSM (flag sets override clears)
  always_comb begin
    state_d = state_q;
    br_d    = br_q;
    pd_d    = pd_q;
    tr_d    = tr_q;
    cnt_d   = cnt_q;
    rdy_d   = rdy_q;
    ien_d   = ien_q;
    ovr_d   = ovr_q;
    toerr_d = toerr_q;

    if (wr_sr) begin
      ien_d = i_din[0];
      if (i_din[1]) ovr_d   = 1'b0;
      if (i_din[2]) toerr_d = 1'b0;
    end

    // A full BR can only be drained by the FSM, so a write while full is an overrun
    if (wr_br) begin
      if (rdy_q) begin
        br_d  = i_din;
        rdy_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (!rdy_q && i_rdy) begin
          pd_d    = br_q;
          tr_d    = 1'b1;
          rdy_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (!i_rdy) begin
          tr_d    = 1'b0;
          state_d = S_WAIT;
        end else if (cnt_q == CW'(REQ_TIMEOUT - 1)) begin
          tr_d    = 1'b0;
          toerr_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (i_rdy) state_d = S_IDLE;
      end
      default: begin
        tr_d    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Side-effect-free CPU read mux
  always_comb begin
    o_dout = '0;
    if (i_cs && !i_rw) begin
      o_dout = i_addr ? br_q : DW'(sr);
    end
  end

  assign o_irq = ien_q & rdy_q;
  assign o_tr  = tr_q;
  assign o_pd  = pd_q;

endmodule

// File: tb/tb_poc_ctrl.sv
// tb_poc_ctrl: directed bench with read/print scoreboards and a behavioural 8-cycle printer.
module tb_poc_ctrl;

  logic       clk;
  logic       rst;
  logic       cs;
  logic       rw;
  logic       addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;
  logic       rdy;
  logic       tr;
  logic [7:0] pd;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_rd[$];
  logic [7:0] exp_print[$];

  logic prn_en = 1'b1;
  logic chk_pd = 1'b1;
  logic busy   = 1'b0;

  poc_ctrl #(.DW(8), .REQ_TIMEOUT(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_cs  (cs),
    .i_rw  (rw),
    .i_addr(addr),
    .i_din (din),
    .o_dout(dout),
    .o_irq (irq),
    .i_rdy (rdy),
    .o_tr  (tr),
    .o_pd  (pd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wr(input logic a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rw = 1'b1; addr = a; din = d;
  endtask

  task automatic rd(input logic a, input logic [7:0] e);
    @(negedge clk);
    cs = 1'b1; rw = 1'b0; addr = a; din = 8'h00;
    exp_rd.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cs = 1'b0; rw = 1'b0;
    end
  endtask

  // Waits (bounded) for o_tr to rise, then returns how many negedges it stayed high
  task automatic count_tr(output int n);
    int w;
    w = 0;
    n = 0;
    while (!tr && w < 20) begin
      @(negedge clk); cs = 1'b0; #2; w++;
    end
    if (!tr) begin
      checks++; errors++;
      $display("FAIL tr_rise_timeout actual=0 required=1");
    end
    while (tr && n < 60) begin
      n++;
      @(negedge clk); cs = 1'b0; #2;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_print.size() != 0 || busy) && n < 400) begin
      @(negedge clk); cs = 1'b0; n++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL wait_done_timeout actual=%0d required=0 pending", exp_print.size());
    end
    idle(2);
  endtask

  // Read monitor: every CPU read cycle is matched against the next queued expectation
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (cs && !rw) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL read_unexpected actual=%0h required=none", dout);
        end else begin
          e = exp_rd.pop_front();
          check(addr ? "read_br" : "read_sr", 32'(dout), 32'(e));
        end
      end
    end
  end

  // Printer model: drops RDY one cycle after seeing TR, busy 8 cycles, then reports the byte
  initial begin
    logic [7:0] pdata;
    logic [7:0] e;
    rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (!prn_en) begin
        rdy = 1'b1;
      end else if (tr === 1'b1) begin
        busy = 1'b1;
        @(posedge clk); #1;
        rdy   = 1'b0;
        pdata = pd;
        repeat (8) begin
          @(negedge clk);
          if (chk_pd) check("pd_stable", 32'(pd), 32'(pdata));
        end
        rdy = 1'b1;
        if (exp_print.size() == 0) begin
          checks++; errors++;
          $display("FAIL print_unexpected actual=%0h required=none", pdata);
        end else begin
          e = exp_print.pop_front();
          check("print_data", 32'(pdata), 32'(e));
        end
        busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;
    rst = 1'b1; cs = 1'b0; rw = 1'b0; addr = 1'b0; din = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    idle(1); #2;
    check("rst_tr", 32'(tr), 32'd0);
    check("rst_pd", 32'(pd), 32'h00);
    check("rst_irq", 32'(irq), 32'd0);
    check("dout_no_cs", 32'(dout), 32'h00);
    rd(1'b0, 8'h80);
    rd(1'b1, 8'h00);
    idle(1);

    // Single byte: RDY low for one cycle, TR high for two, data held through the print
    exp_print.push_back(8'hA5);
    wr(1'b1, 8'hA5);
    rd(1'b0, 8'h00);
    rd(1'b0, 8'h80);
    #2;
    check("tr_start", 32'(tr), 32'd1);
    check("pd_a5", 32'(pd), 32'hA5);
    count_tr(n);
    check("tr_high_cycles", 32'(n), 32'd2);
    wait_done();

    // Interrupt mode with back-to-back bytes; second byte waits in BR
    wr(1'b0, 8'h01);
    idle(1); #2;
    check("irq_en", 32'(irq), 32'd1);
    exp_print.push_back(8'h11);
    exp_print.push_back(8'h22);
    wr(1'b1, 8'h11);
    idle(1); #2;
    check("irq_full", 32'(irq), 32'd0);
    idle(1); #2;
    check("irq_freed", 32'(irq), 32'd1);
    wr(1'b1, 8'h22);
    rd(1'b1, 8'h22);
    #2;
    check("irq_full2", 32'(irq), 32'd0);
    idle(1);
    wait_done();
    #2;
    check("irq_empty", 32'(irq), 32'd1);
    wr(1'b0, 8'h00);
    idle(1); #2;
    check("irq_off", 32'(irq), 32'd0);

    // Overrun: second write discarded, OVR sticky until write-1-to-clear
    exp_print.push_back(8'h33);
    wr(1'b1, 8'h33);
    wr(1'b1, 8'h44);
    rd(1'b0, 8'h82);
    rd(1'b1, 8'h33);
    wr(1'b0, 8'h02);
    rd(1'b0, 8'h80);
    idle(1);
    wait_done();

    // Timeout: printer never answers
    prn_en = 1'b0;
    idle(2);
    wr(1'b1, 8'h5A);
    idle(1);
    count_tr(n);
    check("timeout_tr_cycles", 32'(n), 32'd16);
    rd(1'b0, 8'h84);
    wr(1'b0, 8'h04);
    rd(1'b0, 8'h80);
    idle(3); #2;
    check("timeout_no_retry", 32'(tr), 32'd0);
    prn_en = 1'b1;
    idle(2);

    // Reset while waiting on a busy printer
    chk_pd = 1'b0;
    exp_print.push_back(8'h77);
    wr(1'b1, 8'h77);
    idle(1);
    count_tr(n);
    check("pre_rst_tr_cycles", 32'(n), 32'd2);
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("midrst_tr", 32'(tr), 32'd0);
    check("midrst_pd", 32'(pd), 32'h00);
    check("midrst_irq", 32'(irq), 32'd0);
    rd(1'b0, 8'h80);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk); cs = 1'b0; #2;
      if (tr) seen = 1'b1;
    end
    check("no_tr_after_rst", 32'(seen), 32'd0);
    wait_done();
    chk_pd = 1'b1;
    exp_print.push_back(8'h88);
    wr(1'b1, 8'h88);
    idle(1);
    wait_done();

    check("print_queue_empty", 32'(exp_print.size()), 32'd0);
    check("read_queue_empty", 32'(exp_rd.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
